// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-memory access controller.
// Loads and full-word stores go straight to the SRAM; byte/half stores run a
// read-modify-write. The pipeline is stalled (o_req_ready low) while busy.
// Optional feature macro: DMEM_MISALIGN_CHK_EN (misaligned-access error response).
module dmem_access_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_is_store,
  input  logic [2:0]            i_req_funct3,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_dmem_en,
  output logic                  o_dmem_we,
  output logic [ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wr_data,
  input  logic [DATA_WIDTH-1:0] i_dmem_rd_data
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RDW, S_WR, S_RSP} state_e;

  state_e                state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic       accept, supported, misal;
  logic [7:0] rd_byte;
  logic [15:0] rd_half;

  // Request decode at the IDLE boundary: legal funct3 and (optionally) alignment.
  always_comb begin
    accept    = i_req_valid && (state_q == S_IDLE);
    supported = i_req_is_store ? (i_req_funct3 inside {F3_B, F3_H, F3_W})
                               : (i_req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
`ifdef DMEM_MISALIGN_CHK_EN
    misal = supported &&
            ((((i_req_funct3 == F3_H) || (i_req_funct3 == F3_HU)) && i_req_addr[0]) ||
             ((i_req_funct3 == F3_W) && (i_req_addr[1:0] != 2'b00)));
`else
    misal = 1'b0;
`endif
  end

  // State register plus latched request/response datapath.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic; rejected or misaligned requests skip straight to RSP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (!supported || misal)                      state_d = S_RSP;
        else if (i_req_is_store && i_req_funct3 == F3_W) state_d = S_WR;
        else                                          state_d = S_RD;
      end
      S_RD:    state_d = S_RDW;
      S_RDW:   state_d = is_store_q ? S_WR : S_RSP;
      S_WR:    state_d = S_RSP;
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane selection from the SRAM read word (little-endian).
  always_comb begin
    case (addr_q[1:0])
      2'd0:    rd_byte = i_dmem_rd_data[7:0];
      2'd1:    rd_byte = i_dmem_rd_data[15:8];
      2'd2:    rd_byte = i_dmem_rd_data[23:16];
      default: rd_byte = i_dmem_rd_data[31:24];
    endcase
    rd_half = addr_q[1] ? i_dmem_rd_data[31:16] : i_dmem_rd_data[15:0];
  end

  // Datapath: latch at accept, then extend load data or merge store bytes in RDW.
  always_comb begin
    is_store_d = is_store_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    if (accept) begin
      is_store_d = i_req_is_store;
      f3_d       = i_req_funct3;
      addr_d     = i_req_addr;
      wdata_d    = i_req_wdata;
      rdata_d    = '0;
      err_d      = misal;
    end else if (state_q == S_RDW) begin
      if (is_store_q) begin
        wdata_d = i_dmem_rd_data;
        if (f3_q == F3_B) begin
          case (addr_q[1:0])
            2'd0:    wdata_d[7:0]   = wdata_q[7:0];
            2'd1:    wdata_d[15:8]  = wdata_q[7:0];
            2'd2:    wdata_d[23:16] = wdata_q[7:0];
            default: wdata_d[31:24] = wdata_q[7:0];
          endcase
        end else if (addr_q[1]) begin
          wdata_d[31:16] = wdata_q[15:0];
        end else begin
          wdata_d[15:0]  = wdata_q[15:0];
        end
      end else begin
        case (f3_q)
          F3_B:    rdata_d = {{24{rd_byte[7]}}, rd_byte};
          F3_BU:   rdata_d = {24'd0, rd_byte};
          F3_H:    rdata_d = {{16{rd_half[15]}}, rd_half};
          F3_HU:   rdata_d = {16'd0, rd_half};
          default: rdata_d = i_dmem_rd_data;
        endcase
      end
    end
  end

  // Outputs decoded from the state register or driven straight from flops.
  always_comb begin
    o_req_ready    = (state_q == S_IDLE);
    o_rsp_valid    = (state_q == S_RSP);
    o_dmem_en      = (state_q == S_RD) || (state_q == S_WR);
    o_dmem_we      = (state_q == S_WR);
    o_dmem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    o_dmem_wr_data = wdata_q;
    o_rsp_rdata    = rdata_q;
    o_rsp_err      = err_q;
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl: SRAM model, directed cases and random
// transactions scored against a transaction-level reference memory.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_f3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        dmem_en, dmem_we;
  logic [31:0] dmem_addr, dmem_wr_data, dmem_rd_data;

  logic [31:0] mem     [16];
  logic [31:0] ref_mem [16];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_is_store(req_is_store), .i_req_funct3(req_f3),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_dmem_en(dmem_en), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wr_data(dmem_wr_data), .i_dmem_rd_data(dmem_rd_data)
  );

  // 1-cycle-read synchronous SRAM, 16 words indexed by address bits [5:2].
  always @(posedge clk) begin
    if (dmem_en) begin
      if (dmem_we) mem[dmem_addr[5:2]] <= dmem_wr_data;
      else         dmem_rd_data <= mem[dmem_addr[5:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] w);
    mem[idx] = w;
    ref_mem[idx] = w;
  endtask

  // One request; expected timing and data derived from the access rules.
  task automatic do_req(input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] w, b, h, sh, mask, exp_rdata, exp_wr;
    logic [31:0] got_rdata, got_wr;
    logic        ok, mis, exp_err, got_err;
    int          exp_lat, exp_rd, exp_we, rsp_cyc, rd_cyc, we_cyc;
    w  = ref_mem[addr[5:2]];
    ok = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    mis = ok && ((((f3 == 3'd1) || (f3 == 3'd5)) && addr[0]) ||
                 ((f3 == 3'd2) && (addr[1:0] != 2'b00)));
`endif
    exp_rdata = 0; exp_wr = 0; exp_err = mis; exp_rd = 0; exp_we = 0;
    sh = 32'(addr[1:0]) * 8;
    b  = (w >> sh) & 32'hFF;
    h  = addr[1] ? (w >> 16) : (w & 32'hFFFF);
    if (!ok || mis) exp_lat = 1;
    else if (!st) begin
      exp_lat = 3; exp_rd = 1;
      case (f3)
        3'd0: exp_rdata = (b >= 128) ? (b | 32'hFFFFFF00) : b;
        3'd4: exp_rdata = b;
        3'd1: exp_rdata = (h >= 32768) ? (h | 32'hFFFF0000) : h;
        3'd5: exp_rdata = h;
        default: exp_rdata = w;
      endcase
    end else if (f3 == 3'd2) begin
      exp_lat = 2; exp_we = 1; exp_wr = wd;
    end else begin
      exp_lat = 4; exp_rd = 1; exp_we = 3;
      if (f3 == 3'd0) begin
        mask = 32'hFF << sh;
        exp_wr = (w & ~mask) | ((wd & 32'hFF) << sh);
      end else begin
        sh = addr[1] ? 16 : 0;
        mask = 32'hFFFF << sh;
        exp_wr = (w & ~mask) | ((wd & 32'hFFFF) << sh);
      end
    end

    @(negedge clk);
    chk("ready_before", 32'(req_ready), 1);
    req_valid = 1; req_is_store = st; req_f3 = f3; req_addr = addr; req_wdata = wd;
    rsp_cyc = 0; rd_cyc = 0; we_cyc = 0; got_rdata = 0; got_wr = 0; got_err = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) chk("ready_busy", 32'(req_ready), 0);
      if (dmem_en) begin
        chk("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
        if (dmem_we) begin we_cyc = cyc; got_wr = dmem_wr_data; end
        else rd_cyc = cyc;
      end
      if (rsp_valid) begin
        rsp_cyc = cyc; got_rdata = rsp_rdata; got_err = rsp_err;
        break;
      end
      // Busy: garbage on the request port must be ignored.
      req_is_store = 1'($urandom()); req_f3 = 3'($urandom());
      req_addr = $urandom(); req_wdata = $urandom();
    end
    chk("rsp_latency", rsp_cyc, exp_lat);
    chk("rd_cycle", rd_cyc, exp_rd);
    chk("we_cycle", we_cyc, exp_we);
    chk("rsp_rdata", got_rdata, exp_rdata);
    chk("rsp_err", 32'(got_err), 32'(exp_err));
    if (exp_we != 0) begin
      chk("wr_data", got_wr, exp_wr);
      ref_mem[addr[5:2]] = exp_wr;
    end
    // Request held through RSP must not be taken until IDLE.
    req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    chk("post_rsp_idle", {29'd0, req_ready, dmem_en, rsp_valid}, 32'b100);
    @(posedge clk); #1;
    chk("no_accept_in_rsp", {30'd0, req_ready, dmem_en}, 32'b10);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [2:0]  f;
    logic        s;
    rst = 1; req_valid = 0; req_is_store = 0; req_f3 = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < 16; i++) set_word(i, $urandom());
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {24'd0, req_ready, rsp_valid, rsp_err, dmem_en, dmem_we, 3'd0}, 32'h80);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wr_data, 0);
    @(negedge clk); rst = 0;

    // Directed cases.
    set_word(4, 32'h8899AABB);
    do_req(0, 3'd2, 32'h10, 0);
    do_req(0, 3'd0, 32'h13, 0);
    do_req(0, 3'd4, 32'h13, 0);
    do_req(1, 3'd0, 32'h11, 32'h000000CC);
    set_word(4, 32'h8899AABB);
    do_req(1, 3'd1, 32'h12, 32'h00001234);
    do_req(1, 3'd2, 32'h14, 32'hDEADBEEF);
    do_req(0, 3'd2, 32'h11, 0);
    do_req(1, 3'd1, 32'h13, 32'h5555);
    do_req(0, 3'd3, 32'h10, 0);
    do_req(1, 3'd5, 32'h10, 32'h77);

    // Reset during RDW of an SB: no write, no response, memory untouched.
    set_word(4, 32'h8899AABB);
    @(negedge clk);
    req_valid = 1; req_is_store = 1; req_f3 = 3'd0; req_addr = 32'h11; req_wdata = 32'hCC;
    @(posedge clk); #1; req_valid = 0;
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_outputs", {29'd0, req_ready, dmem_en, rsp_valid}, 32'b100);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_quiet", {30'd0, dmem_we, rsp_valid}, 0);
    end
    chk("rst_mid_mem", mem[4], 32'h8899AABB);

    // Random transactions.
    for (int n = 0; n < 300; n++) begin
      s = 1'($urandom());
      f = ($urandom_range(0, 9) == 0) ? 3'($urandom()) : (s ? 3'($urandom_range(0, 2))
          : ((n % 5 == 0) ? 3'd2 : 3'($urandom_range(0, 5))));
      a = $urandom(); d = $urandom();
      do_req(s, f, a, d);
    end

    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
